fft_reorder_buffer: RTL and testbench

FFT_REORDER_BUFFER -- requirements
Module: fft_reorder_buffer

---
 rtl/fft_reorder_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_fft_reorder_buffer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder_buffer.sv
// -----------------------------------------------------------------------------
// fft_reorder_buffer
//
// Purpose:
//   Converts a 16-point radix-4 FFT output stream from digit-reversed order
//   into natural bin order. Each write is stored at the base-4 digit-reversed
//   address of its arrival count. The storage is then read out sequentially.
//
// Configuration:
//   FFT_REORDER_PINGPONG_EN defined   -> two banks. One frame fills while the
//                                        previous frame drains.
//   FFT_REORDER_PINGPONG_EN undefined -> one bank. The write side stalls from
//                                        the 16th write until the frame has
//                                        fully drained.
//
// Ports:
//   clk, rst                : clock and asynchronous active-high reset
//   in_valid/in_ready       : write-side handshake
//   in_re/in_im             : input sample, digit-reversed order (signed)
//   out_valid/out_ready     : read-side handshake
//   out_re/out_im           : output sample, natural order (registered)
//   out_index               : bin number of the presented sample
//   out_last                : high with bin 15
// -----------------------------------------------------------------------------
module fft_reorder_buffer #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic [3:0]               out_index,
    output logic                     out_last
);

`ifdef FFT_REORDER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int AW = (NB == 2) ? 5 : 4;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    // Two state slots always exist. In single-bank builds the bank pointers
    // never leave 0, so slot 1 stays EMPTY and its logic is trimmed away.
    bank_state_t r_state [2];
    bank_state_t w_state_next [2];

    logic [2*DATA_W-1:0] r_mem [0:NB*16-1];

    logic [3:0]               r_w;
    logic [3:0]               r_r;
    logic                     r_wr_bank;
    logic                     r_rd_bank;
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_re;
    logic signed [DATA_W-1:0] r_out_im;
    logic                     r_out_last;

    logic          w_wr_fire;
    logic          w_wr_last;
    logic          w_rd_fire;
    logic          w_rd_last;
    logic          w_rd_bank_next;
    logic          w_next_full;
    logic          w_load_first;
    logic          w_load_seq;
    logic [3:0]    w_rev;
    logic [3:0]    w_rd_sub;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;

    // ---------------------------------------------------------------- control
    assign in_ready  = (r_state[r_wr_bank] == BANK_EMPTY) ||
                       (r_state[r_wr_bank] == BANK_FILLING);
    assign w_wr_fire = in_valid && in_ready;
    assign w_wr_last = w_wr_fire && (r_w == 4'd15);
    assign w_rd_fire = r_out_valid && out_ready;
    assign w_rd_last = w_rd_fire && (r_r == 4'd15);

    // The reader moves to the other bank only after the last bin has been taken.
    assign w_rd_bank_next = (w_rd_last && (NB == 2)) ? ~r_rd_bank : r_rd_bank;

    // A bank that completes its 16th write on this edge counts as full. This
    // gives the one-cycle latency from the last input to bin 0. It also lets
    // the ping-pong build present back-to-back frames with no bubble.
    assign w_next_full  = (r_state[w_rd_bank_next] == BANK_FULL) ||
                          (w_wr_last && (r_wr_bank == w_rd_bank_next));
    assign w_load_first = (!r_out_valid || w_rd_last) && w_next_full;
    assign w_load_seq   = w_rd_fire && !w_rd_last;

    // w = 4a + b is stored at 4b + a (swap the two base-4 digits).
    assign w_rev    = {r_w[1:0], r_w[3:2]};
    assign w_rd_sub = w_load_first ? 4'd0 : 4'(r_r + 4'd1);

    generate
        if (NB == 2) begin : g_addr_pp
            assign w_wr_addr = {r_wr_bank, w_rev};
            assign w_rd_addr = {w_rd_bank_next, w_rd_sub};
        end else begin : g_addr_single
            assign w_wr_addr = w_rev;
            assign w_rd_addr = w_rd_sub;
        end
    endgenerate

    // ------------------------------------------------------ bank state FSMs
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_next[b] = r_state[b];
            if (w_rd_last && (r_rd_bank == b[0])) begin
                w_state_next[b] = BANK_EMPTY;
            end else if (w_load_first && (w_rd_bank_next == b[0])) begin
                w_state_next[b] = BANK_DRAINING;
            end else if (w_wr_last && (r_wr_bank == b[0])) begin
                w_state_next[b] = BANK_FULL;
            end else if (w_wr_fire && (r_wr_bank == b[0])) begin
                w_state_next[b] = BANK_FILLING;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                r_state[b] <= BANK_EMPTY;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                r_state[b] <= w_state_next[b];
            end
        end
    end

    // --------------------------------------------------------- write side
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w       <= 4'd0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_w <= 4'(r_w + 4'd1);
            end
            if (w_wr_last && (NB == 2)) begin
                r_wr_bank <= ~r_wr_bank;
            end
            r_rd_bank <= w_rd_bank_next;
        end
    end

    // Storage is not reset. Bank state alone decides what gets read.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[w_wr_addr] <= {in_re, in_im};
        end
    end

    // ------------------------------------------------ read side (registered)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_r         <= 4'd0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load_first) begin
            r_out_valid            <= 1'b1;
            r_r                    <= 4'd0;
            {r_out_re, r_out_im}   <= r_mem[w_rd_addr];
            r_out_last             <= 1'b0;
        end else if (w_load_seq) begin
            r_r                    <= 4'(r_r + 4'd1);
            {r_out_re, r_out_im}   <= r_mem[w_rd_addr];
            r_out_last             <= (r_r == 4'd14);
        end else if (w_rd_last) begin
            r_out_valid <= 1'b0;
            r_r         <= 4'd0;
            r_out_last  <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_index = r_r;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_fft_reorder_buffer.sv
module tb_fft_reorder_buffer;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_re = '0;
    logic signed [DW-1:0] in_im = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    logic [3:0]           out_index;
    logic                 out_last;

    fft_reorder_buffer #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_index (out_index),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Natural bin k holds the sample that arrived as write number exp_seq[k].
    int exp_seq [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    int fr_re [16];
    int fr_im [16];

    typedef struct {
        int in_re;
        int in_im;
        int exp_idx;
        int exp_re;
        int exp_im;
        int exp_last;
    } vec_t;
    vec_t vecs [16];

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        if (!out_valid) chk(nm, 0, 1);
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (!in_ready) chk(nm, 0, 1);
    endtask

    // Writes fr_re/fr_im; gap inserts one idle cycle after each write.
    task automatic write_frame(input int gap);
        for (int w = 0; w < 16; w++) begin
            in_valid = 1'b1;
            in_re    = DW'(fr_re[w]);
            in_im    = DW'(fr_im[w]);
            wait_ready("wr_ready_timeout");
            if (w == 15) chk("no_valid_before_last_write", int'(out_valid), 0);
            step();
            in_valid = 1'b0;
            if (gap != 0 && w != 15) step();
        end
    endtask

    task automatic drain_frame(input int stall_idx, input int stall_len);
        for (int k = 0; k < 16; k++) begin
            wait_valid("rd_valid_timeout");
            chk("rd_index", int'(out_index), k);
            chk("rd_re", int'(out_re), fr_re[exp_seq[k]]);
            chk("rd_im", int'(out_im), fr_im[exp_seq[k]]);
            chk("rd_last", int'(out_last), (k == 15) ? 1 : 0);
            $display("read bin %0d re=%0d im=%0d last=%0d", out_index, out_re, out_im, out_last);
            if (k == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    chk("stall_valid", int'(out_valid), 1);
                    chk("stall_re_held", int'(out_re), fr_re[exp_seq[k]]);
                    chk("stall_index_held", int'(out_index), k);
                end
                out_ready = 1'b1;
            end
            step();
        end
        chk("drained_valid_low", int'(out_valid), 0);
    endtask

    initial begin
        int c15;
        int c16;
        int wr_n;
        int low_cnt;
        int first_low;

        for (int i = 0; i < 16; i++) begin
            vecs[i].in_re    = i;
            vecs[i].in_im    = -i;
            vecs[i].exp_idx  = i;
            vecs[i].exp_re   = exp_seq[i];
            vecs[i].exp_im   = -exp_seq[i];
            vecs[i].exp_last = (i == 15) ? 1 : 0;
        end

        // Reset state.
        step();
        step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_re", int'(out_re), 0);
        chk("rst_out_im", int'(out_im), 0);
        chk("rst_out_index", int'(out_index), 0);
        chk("rst_out_last", int'(out_last), 0);
        rst = 1'b0;
        step();
        chk("rst_in_ready", int'(in_ready), 1);

        // Basic frame from the vector table, with a check of 1-cycle latency.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_re    = DW'(vecs[i].in_re);
            in_im    = DW'(vecs[i].in_im);
            chk("tbl_in_ready", int'(in_ready), 1);
            $display("write w=%0d re=%0d im=%0d", i, in_re, in_im);
            step();
        end
        in_valid = 1'b0;
        chk("tbl_latency_valid", int'(out_valid), 1);
        for (int i = 0; i < 16; i++) begin
            wait_valid("tbl_valid_timeout");
            chk("tbl_index", int'(out_index), vecs[i].exp_idx);
            chk("tbl_re", int'(out_re), vecs[i].exp_re);
            chk("tbl_im", int'(out_im), vecs[i].exp_im);
            chk("tbl_last", int'(out_last), vecs[i].exp_last);
            $display("read bin %0d re=%0d im=%0d last=%0d", out_index, out_re, out_im, out_last);
            step();
        end
        chk("tbl_drained", int'(out_valid), 0);

        // Backpressure: stall 5 cycles while bin 3 (value 12) is presented.
        for (int w = 0; w < 16; w++) begin
            fr_re[w] = w;
            fr_im[w] = -w;
        end
        write_frame(0);
        chk("stall_latency_valid", int'(out_valid), 1);
        drain_frame(3, 5);

        // Back-to-back frames with in_valid held high.
        c15 = 0;
        c16 = 0;
        wr_n = 0;
        low_cnt = 0;
        first_low = -1;
        fork
            begin
                int guard = 0;
                while (wr_n < 32 && guard < 300) begin
                    int v;
                    bit xfer;
                    v = (wr_n < 16) ? wr_n : 100 + wr_n - 16;
                    in_valid = 1'b1;
                    in_re    = DW'(v);
                    in_im    = DW'(-v);
                    xfer     = in_ready;
                    if (!in_ready) begin
                        low_cnt++;
                        if (first_low < 0) first_low = wr_n;
                    end
                    step();
                    guard++;
                    if (xfer) wr_n++;
                end
                in_valid = 1'b0;
            end
            begin
                for (int m = 0; m < 32; m++) begin
                    int e;
                    wait_valid("b2b_valid_timeout");
                    e = (m / 16) * 100 + exp_seq[m % 16];
                    chk("b2b_re", int'(out_re), e);
                    chk("b2b_im", int'(out_im), -e);
                    chk("b2b_index", int'(out_index), m % 16);
                    $display("b2b read m=%0d bin %0d re=%0d", m, out_index, out_re);
                    if (m == 15) c15 = cyc;
                    if (m == 16) c16 = cyc;
                    step();
                end
            end
        join
        chk("b2b_all_written", wr_n, 32);
`ifdef FFT_REORDER_PINGPONG_EN
        chk("b2b_ready_low_cycles", low_cnt, 0);
        chk("b2b_frame_gap", c16 - c15, 1);
`else
        chk("b2b_ready_low_cycles", low_cnt, 16);
        chk("b2b_first_low_at", first_low, 16);
`endif
        step();
        chk("b2b_drained", int'(out_valid), 0);

        // Reset after 9 writes discards the partial frame.
        for (int w = 0; w < 9; w++) begin
            in_valid = 1'b1;
            in_re    = DW'(200 + w);
            in_im    = DW'(-(200 + w));
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_re", int'(out_re), 0);
        step();
        rst = 1'b0;
        step();
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_index", int'(out_index), 0);
        for (int w = 0; w < 16; w++) begin
            fr_re[w] = 50 + w;
            fr_im[w] = -(50 + w);
        end
        write_frame(0);
        chk("midrst_latency_valid", int'(out_valid), 1);
        drain_frame(-1, 0);

        // Full-scale alternating values.
        for (int w = 0; w < 16; w++) begin
            fr_re[w] = (w % 2 == 0) ? 32767 : -32768;
            fr_im[w] = (w % 2 == 0) ? -32768 : 32767;
        end
        write_frame(0);
        drain_frame(-1, 0);

        // in_valid toggling 1-0 every cycle.
        for (int w = 0; w < 16; w++) begin
            fr_re[w] = w;
            fr_im[w] = -w;
        end
        write_frame(1);
        chk("toggle_latency_valid", int'(out_valid), 1);
        drain_frame(-1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
